// File: rtl/conv_seq_ctrl_if.sv
// Bus bundle for conv_seq_ctrl: start/size handshake, X/Y memory read ports
// and the Z memory write port. The master side is the environment, the slave
// side is the sequencer.
interface conv_seq_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              start_i;
    logic [4:0]        size_y_i;
    logic              busy_o;
    logic              done_o;
    logic [4:0]        memx_addr_o;
    logic [4:0]        memy_addr_o;
    logic [DATA_W-1:0] x_data_i;
    logic [DATA_W-1:0] y_data_i;
    logic              memz_we_o;
    logic [5:0]        memz_addr_o;
    logic [15:0]       memz_data_o;

    modport master (
        output start_i, size_y_i, x_data_i, y_data_i,
        input  busy_o, done_o, memx_addr_o, memy_addr_o,
        input  memz_we_o, memz_addr_o, memz_data_o
    );

    modport slave (
        input  start_i, size_y_i, x_data_i, y_data_i,
        output busy_o, done_o, memx_addr_o, memy_addr_o,
        output memz_we_o, memz_addr_o, memz_data_o
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequential convolution controller: z[i] = sum_j y[j] * x[i-j], one
// multiply-accumulate per FETCH/MAC pair, one Z write per output sample.
// Optional feature macro: CONV_SEQ_SAT_EN (accumulator saturates at 16'hFFFF
// instead of wrapping).
module conv_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int SIZE_X = 10
) (
    input logic           clk,
    input logic           rst_a,
    conv_seq_ctrl_if.slave bus
);
    localparam int ProdW = 2 * DATA_W;
    localparam int SumW  = ((ProdW > 16) ? ProdW : 16) + 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StClr, StFetch, StMac, StWrite, StDone
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [4:0]  j_q, j_d;
    logic [4:0]  sy_q, sy_d;
    logic [15:0] acc_q, acc_d;

    logic [7:0]       diff;
    logic             in_range;
    logic [6:0]       last_i;
    logic [ProdW-1:0] prod;
    logic [SumW-1:0]  sum;
    logic [15:0]      acc_mac;

    // Datapath: x index, masking, product and next accumulator value
    always_comb begin
        // i <= 39 and j <= 30, so bit 7 is a reliable sign of i-j
        diff     = {2'b00, i_q} - {3'b000, j_q};
        in_range = !diff[7] && (diff < 8'(SIZE_X));
        prod     = in_range ? (bus.y_data_i * bus.x_data_i) : '0;
        sum      = SumW'(acc_q) + SumW'(prod);
`ifdef CONV_SEQ_SAT_EN
        acc_mac  = (sum > SumW'(17'h0FFFF)) ? 16'hFFFF : sum[15:0];
`else
        acc_mac  = sum[15:0];
`endif
        last_i   = 7'(SIZE_X) + 7'(sy_q) - 7'd2;
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            sy_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            sy_q    <= sy_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, counter updates and Moore outputs
    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        sy_d            = sy_q;
        acc_d           = acc_q;
        bus.busy_o      = (state_q != StIdle);
        bus.done_o      = 1'b0;
        bus.memx_addr_o = '0;
        bus.memy_addr_o = '0;
        bus.memz_we_o   = 1'b0;
        bus.memz_addr_o = '0;
        bus.memz_data_o = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    // Size is captured on the accepting edge so later input
                    // changes cannot leak into the run.
                    sy_d    = bus.size_y_i;
                    state_d = (bus.size_y_i != 5'd0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                i_d     = '0;
                state_d = StClr;
            end
            StClr: begin
                acc_d   = '0;
                j_d     = '0;
                state_d = StFetch;
            end
            StFetch: begin
                bus.memy_addr_o = j_q;
                bus.memx_addr_o = in_range ? diff[4:0] : 5'd0;
                state_d         = StMac;
            end
            StMac: begin
                acc_d = acc_mac;
                if (j_q == sy_q - 5'd1) begin
                    state_d = StWrite;
                end else begin
                    j_d     = j_q + 5'd1;
                    state_d = StFetch;
                end
            end
            StWrite: begin
                bus.memz_we_o   = 1'b1;
                bus.memz_addr_o = i_q;
                bus.memz_data_o = acc_q;
                if ({1'b0, i_q} == last_i) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + 6'd1;
                    state_d = StClr;
                end
            end
            StDone: begin
                bus.done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: a direct convolution model builds the
// expected Z writes; a negedge monitor compares every write and done pulse.
module tb_conv_seq_ctrl;
    localparam int DATA_W = 8;
    localparam int SIZE_X = 10;

    logic clk = 1'b0;
    logic rst_a;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

    conv_seq_ctrl #(.DATA_W(DATA_W), .SIZE_X(SIZE_X)) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] x_mem [32];
    logic [7:0] y_mem [32];
    int exp_addr [$];
    int exp_data [$];
    int nwrites;
    int done_seen;
    int done_cyc;
    int busy_at_done;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Synchronous-read memories: data valid one cycle after the address
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.x_data_i <= x_mem[bus.memx_addr_o];
        bus.y_data_i <= y_mem[bus.memy_addr_o];
    end

    // Compare process: every Z write against the model, done pulses recorded
    always @(negedge clk) begin
        if (!rst_a && bus.memz_we_o) begin
            nwrites++;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr %0d data %0d required none",
                         bus.memz_addr_o, bus.memz_data_o);
            end else begin
                check("z_addr", int'(bus.memz_addr_o), exp_addr.pop_front());
                check("z_data", int'(bus.memz_data_o), exp_data.pop_front());
            end
        end
        if (!rst_a && bus.done_o) begin
            done_seen++;
            done_cyc     = cyc;
            busy_at_done = int'(bus.busy_o);
        end
    end

    // Model: plain convolution, then wrap or clamp the exact total
    task automatic build(input int sy);
        int sz;
        longint total;
        exp_addr.delete();
        exp_data.delete();
        sz = (sy == 0) ? 0 : SIZE_X + sy - 1;
        for (int i = 0; i < sz; i++) begin
            total = 0;
            for (int j = 0; j < sy; j++) begin
                if (i - j >= 0 && i - j < SIZE_X)
                    total += longint'(y_mem[j]) * longint'(x_mem[i - j]);
            end
`ifdef CONV_SEQ_SAT_EN
            if (total > 65535) total = 65535;
`else
            total = total % 65536;
`endif
            exp_addr.push_back(i);
            exp_data.push_back(int'(total));
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, int'(bus.busy_o), 0);
        check({name, "_done"}, int'(bus.done_o), 0);
        check({name, "_we"}, int'(bus.memz_we_o), 0);
        check({name, "_addrs"},
              int'({bus.memx_addr_o, bus.memy_addr_o, bus.memz_addr_o}), 0);
        check({name, "_zdata"}, int'(bus.memz_data_o), 0);
    endtask

    // One complete run; optional stray start pulse and size churn while busy
    task automatic run(input int sy, input bit extra_start, input bit vary_size);
        int sz, lat, start_cyc;
        sz  = (sy == 0) ? 0 : SIZE_X + sy - 1;
        lat = (sy == 0) ? 0 : 1 + sz * (2 * sy + 2);
        build(sy);
        nwrites   = 0;
        done_seen = 0;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.size_y_i = 5'(sy);
        @(negedge clk);
        bus.start_i = 1'b0;
        start_cyc   = cyc;
        check("busy_after_start", int'(bus.busy_o), 1);
        for (int n = 0; n < lat + 20 && done_seen == 0; n++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (extra_start && n == 20) begin
                bus.start_i  = 1'b1;
                bus.size_y_i = 5'($urandom_range(0, 31));
            end
            if (vary_size) bus.size_y_i = 5'($urandom_range(0, 31));
        end
        bus.start_i = 1'b0;
        check("done_seen", done_seen, 1);
        check("done_latency", done_cyc - start_cyc, lat);
        check("busy_at_done", busy_at_done, 1);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done_o), 0);
        check("busy_after_done", int'(bus.busy_o), 0);
        check("write_count", nwrites, sz);
        check("writes_left", exp_addr.size(), 0);
    endtask

    initial begin
        int lit [14] = '{0, 1, 3, 6, 10, 10, 10, 10, 10, 10, 10, 9, 7, 4};
        int wait_n;
        bus.start_i  = 1'b0;
        bus.size_y_i = '0;
        for (int k = 0; k < 32; k++) begin
            x_mem[k] = 8'($urandom);
            y_mem[k] = 8'($urandom);
        end
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_a = 1'b0;

        // Reference vector: x=1, y=0..4; pin the model to literal values
        for (int k = 0; k < SIZE_X; k++) x_mem[k] = 8'd1;
        for (int k = 0; k < 5; k++) y_mem[k] = 8'(k);
        build(5);
        check("model_len", exp_data.size(), 14);
        for (int k = 0; k < 14; k++) check("model_pin", exp_data[k], lit[k]);
        run(5, 1'b0, 1'b0);

        // Zero-length Y: straight to done, no writes
        run(0, 1'b0, 1'b0);

        // Stray start and size churn while busy must be ignored
        run(5, 1'b1, 1'b1);

        // Reset after the third write, then restart
        build(5);
        nwrites = 0;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.size_y_i = 5'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_n = 0;
        while (nwrites < 3 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check("third_write_seen", nwrites, 3);
        rst_a = 1'b1;
        #1;
        check_outputs_zero("midrun_reset");
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        check_outputs_zero("reset_held");
        rst_a = 1'b0;
        repeat (40) @(negedge clk);
        check("no_write_after_reset", nwrites, 3);
        check("idle_after_reset", int'(bus.busy_o), 0);
        run(5, 1'b0, 1'b0);

        // Full-scale operands: wrap vs saturate
        for (int k = 0; k < SIZE_X; k++) x_mem[k] = 8'hFF;
        y_mem[0] = 8'hFF;
        y_mem[1] = 8'hFF;
        build(2);
`ifdef CONV_SEQ_SAT_EN
        check("model_pin_sat", exp_data[1], 32'hFFFF);
`else
        check("model_pin_wrap", exp_data[1], 32'hFC02);
`endif
        run(2, 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                x_mem[k] = 8'($urandom);
                y_mem[k] = 8'($urandom);
            end
            run(int'($urandom_range(1, 8)), r[0], r[1]);
        end

        // Longest Y
        for (int k = 0; k < 32; k++) begin
            x_mem[k] = 8'($urandom);
            y_mem[k] = 8'($urandom);
        end
        run(31, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of X and Y memory read data, unsigned.
REQ-002 SHALL have parameter SIZE_X, default 10: fixed X-vector length.
REQ-003 SHALL have clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_a  input  1: asynchronous, active-high reset.
REQ-005 SHALL have start_i  input  1: one-cycle start request.
REQ-006 SHALL have size_y_i  input  5: Y-vector length, sampled on an accepted start.
REQ-007 SHALL have busy_o  output  1: high from accepted start until DONE is left.
REQ-008 SHALL have done_o  output  1: one-cycle completion pulse.
REQ-009 SHALL have memx_addr_o  output  5: X memory read address.
REQ-010 SHALL have memy_addr_o  output  5: Y memory read address.
REQ-011 SHALL have x_data_i  input  DATA_W: X read data, valid 1 cycle after the address.
REQ-012 SHALL have y_data_i  input  DATA_W: Y read data, valid 1 cycle after the address.
REQ-013 SHALL have memz_we_o  output  1: Z memory write strobe.
REQ-014 SHALL have memz_addr_o  output  6: Z memory write address.
REQ-015 SHALL have memz_data_o  output  16: Z write data.

Function
REQ-016 SHALL compute z[i] = sum over j=0..sy-1 of y[j]*x[i-j], for i=0..sz-1, where sy is the latched size_y_i and sz = SIZE_X+sy-1; a term SHALL contribute 0 when i-j<0 or i-j>=SIZE_X.
REQ-017 SHALL use FSM states IDLE, LOAD, CLR, FETCH, MAC, WRITE, DONE.
REQ-018 IDLE SHALL go to LOAD on start_i=1 with size_y_i!=0, and to DONE on start_i=1 with size_y_i=0.
REQ-019 LOAD SHALL latch sy, set i=0, and go to CLR.
REQ-020 CLR SHALL set acc=0 and j=0, then go to FETCH.
REQ-021 FETCH SHALL drive memy_addr_o=j and memx_addr_o=i-j (0 when out of range), then go to MAC.
REQ-022 MAC SHALL add y_data_i*x_data_i to acc, or 0 when the term is masked.
REQ-023 MAC SHALL then go to WRITE when j=sy-1; otherwise it SHALL increment j and go to FETCH.
REQ-024 WRITE SHALL assert memz_we_o for exactly 1 cycle with memz_addr_o=i and memz_data_o=acc.
REQ-025 WRITE SHALL go to DONE when i=sz-1; otherwise it SHALL increment i and go to CLR.
REQ-026 DONE SHALL assert done_o for 1 cycle, then go to IDLE.
REQ-027 Latency: DONE SHALL be entered 1+sz*(2*sy+2) edges after the edge that samples start, which is 169 edges for sy=5.
REQ-028 Arithmetic: the product SHALL be 2*DATA_W bits; acc SHALL be 16 bits and wrap modulo 2^16.
REQ-029 start_i SHALL be ignored while busy_o=1; size_y_i changes mid-run SHALL have no effect.
REQ-030 memz_we_o SHALL be 0 in every state except WRITE.

Reset
REQ-031 rst_a=1 SHALL force IDLE at any time, including mid-run, and clear i, j, acc and sy.
REQ-032 Under reset SHALL drive busy_o, done_o, memz_we_o, all addresses and memz_data_o to 0.
REQ-033 No Z write SHALL occur after reset assertion; the next start after release SHALL run normally.

Configuration
REQ-034 With CONV_SEQ_SAT_EN defined, acc SHALL saturate at 16'hFFFF instead of wrapping.
REQ-035 Without CONV_SEQ_SAT_EN, acc SHALL wrap per REQ-028; all other behaviour is identical.

Verification
REQ-036 x[0..9]=1, y=0,1,2,3,4, sy=5 -> 14 writes z=0,1,3,6,10,10,10,10,10,10,10,9,7,4 at addr 0..13; done_o 169 edges after start.
REQ-037 start with size_y_i=0 -> DONE the next cycle, done_o pulse, no memz_we_o, busy_o high 1 cycle.
REQ-038 Second start_i pulse mid-run -> ignored; write count and done timing unchanged from REQ-036.
REQ-039 rst_a pulsed after the 3rd write -> IDLE, outputs 0, no further writes; a restart then reproduces REQ-036.
REQ-040 x=y=255, sy=2 -> z[1]=16'hFC02 without CONV_SEQ_SAT_EN and 16'hFFFF with it.
REQ-041 sy=31 -> 40 writes, last memz_addr_o=39; done_o 1+40*64=2561 edges after start.
